// File: rtl/memory_control_pkg.sv
// Shared types for the two-core coherence bus controller: RAM handshake
// states, bus FSM states and block geometry.
package memory_control_pkg;

  localparam int CPUS     = 2;
  localparam int BLKWORDS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE,
    WB,
    SNOOP,
    MEM0,
    MEM1,
    C2C0,
    C2C1,
    INV,
    IFETCH
  } busstate_t;

endpackage

// File: rtl/memory_control_if.sv
// Per-core cache request/response bundle plus the shared RAM port.
// A request (iREN/dREN/dWEN/upgrade) is held until its wait drops low for one
// cycle; load data is valid only in that cycle. RAM completes on ramstate==ACCESS.
interface memory_control_if;
  import memory_control_pkg::*;

  logic  [CPUS-1:0] iREN;
  word_t [CPUS-1:0] iaddr;
  logic  [CPUS-1:0] iwait;
  word_t [CPUS-1:0] iload;

  logic  [CPUS-1:0] dREN;
  logic  [CPUS-1:0] dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic  [CPUS-1:0] dwait;
  word_t [CPUS-1:0] dload;

  logic  [CPUS-1:0] ccwrite;
  logic  [CPUS-1:0] cctrans;
  logic  [CPUS-1:0] ccwait;
  logic  [CPUS-1:0] ccinv;
  word_t [CPUS-1:0] ccsnoopaddr;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_control_rr_arbiter.sv
// Two-way round-robin picker: on a tie the pointer decides, and the pointer
// flips each time the granted transaction completes.
module rr_arbiter
  import memory_control_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic [CPUS-1:0] req,
  input  logic            done,
  output logic            grant
);

  logic ptr;

  always_ff @(posedge CLK) begin
    if (RST) ptr <= 1'b0;
    else if (done) ptr <= ~ptr;
  end

  assign grant = (&req) ? ptr : req[1];

endmodule

// File: rtl/memory_control.sv
// Coherence bus controller: arbitrates icache fetches, dcache fills/writebacks
// and upgrades from two cores onto one RAM port, snooping the other dcache.
module memory_control
  import memory_control_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  memory_control_if.slave  bus,
  output busstate_t        dbg_state
);

  busstate_t state, next, sel_state;
  logic req, next_req, o, inv_phase, next_inv_phase;
  logic grant, done, access;
  logic [CPUS-1:0] sel_vec, up_vec;
  logic [CPUS-1:0] iwait_n, dwait_n, ccwait_n, ccinv_n;
  word_t [CPUS-1:0] iload_n, dload_n, snoop_n;
  logic ram_ren, ram_wen;
  word_t ram_addr, ram_store;

  // ERROR is deliberately not ACCESS, so the controller just keeps waiting.
  assign access = (bus.ramstate == ACCESS);
  assign up_vec = bus.cctrans & bus.ccwrite;

  always_comb begin
    sel_vec   = '0;
    sel_state = IDLE;
    if (|bus.dWEN) begin
      sel_vec = bus.dWEN;   sel_state = WB;
    end else if (|bus.dREN) begin
      sel_vec = bus.dREN;   sel_state = SNOOP;
    end else if (|up_vec) begin
      sel_vec = up_vec;     sel_state = INV;
    end else if (|bus.iREN) begin
      sel_vec = bus.iREN;   sel_state = IFETCH;
    end
  end

  rr_arbiter u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .req   (sel_vec),
    .done  (done),
    .grant (grant)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      req       <= 1'b0;
      o         <= 1'b1;
      inv_phase <= 1'b0;
    end else begin
      state     <= next;
      req       <= next_req;
      o         <= ~next_req;
      inv_phase <= next_inv_phase;
    end
  end

  always_comb begin
    next           = state;
    next_req       = req;
    next_inv_phase = 1'b0;
    done           = 1'b0;
    iwait_n        = '1;
    dwait_n        = '1;
    iload_n        = '0;
    dload_n        = '0;
    ccwait_n       = '0;
    ccinv_n        = '0;
    snoop_n        = '0;
    ram_ren        = 1'b0;
    ram_wen        = 1'b0;
    ram_addr       = '0;
    ram_store      = '0;
    unique case (state)
      IDLE: begin
        if (sel_state != IDLE) begin
          next     = sel_state;
          next_req = grant;
        end
      end
      WB: begin
        if (!bus.dWEN[req]) next = IDLE;
        else begin
          ram_wen   = 1'b1;
          ram_addr  = bus.daddr[req];
          ram_store = bus.dstore[req];
          if (access) begin
            dwait_n[req] = 1'b0;
            done         = 1'b1;
            next         = IDLE;
          end
        end
      end
      SNOOP: begin
        if (!bus.dREN[req]) next = IDLE;
        else begin
          ccwait_n[o] = 1'b1;
          snoop_n[o]  = bus.daddr[req];
          ccinv_n[o]  = bus.ccwrite[req];
          if (bus.cctrans[o]) next = bus.dWEN[o] ? C2C0 : MEM0;
        end
      end
      MEM0, MEM1: begin
        if (!bus.dREN[req]) next = IDLE;
        else begin
          ccwait_n[o]  = 1'b1;
          ram_ren      = 1'b1;
          ram_addr     = bus.daddr[req];
          dload_n[req] = bus.ramload;
          if (access) begin
            dwait_n[req] = 1'b0;
            if (state == MEM1) begin
              next = IDLE;
              done = 1'b1;
            end else next = MEM1;
          end
        end
      end
      C2C0, C2C1: begin
        // The dirty snooper's word goes to the requester and to RAM together.
        if (!bus.dREN[req] || !bus.dWEN[o]) next = IDLE;
        else begin
          ccwait_n[o]  = 1'b1;
          ram_wen      = 1'b1;
          ram_addr     = bus.daddr[o];
          ram_store    = bus.dstore[o];
          dload_n[req] = bus.dstore[o];
          if (access) begin
            dwait_n[req] = 1'b0;
            dwait_n[o]   = 1'b0;
            if (state == C2C1) begin
              next = IDLE;
              done = 1'b1;
            end else next = C2C1;
          end
        end
      end
      INV: begin
        if (!up_vec[req]) next = IDLE;
        else if (!inv_phase) begin
          ccwait_n[o]    = 1'b1;
          ccinv_n[o]     = 1'b1;
          snoop_n[o]     = bus.daddr[req];
          next_inv_phase = 1'b1;
        end else begin
          dwait_n[req] = 1'b0;
          done         = 1'b1;
          next         = IDLE;
        end
      end
      IFETCH: begin
        if (!bus.iREN[req]) next = IDLE;
        else begin
          ram_ren      = 1'b1;
          ram_addr     = bus.iaddr[req];
          iload_n[req] = bus.ramload;
          if (access) begin
            iwait_n[req] = 1'b0;
            done         = 1'b1;
            next         = IDLE;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

  assign bus.iwait       = iwait_n;
  assign bus.iload       = iload_n;
  assign bus.dwait       = dwait_n;
  assign bus.dload       = dload_n;
  assign bus.ccwait      = ccwait_n;
  assign bus.ccinv       = ccinv_n;
  assign bus.ccsnoopaddr = snoop_n;
  assign bus.ramREN      = ram_ren;
  assign bus.ramWEN      = ram_wen;
  assign bus.ramaddr     = ram_addr;
  assign bus.ramstore    = ram_store;
  assign dbg_state       = state;

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control: a latency-programmable RAM model, cache
// driver tasks, and a scoreboard monitor that checks every ack against a queue.
module tb_memory_control;
  import memory_control_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  memory_control_if bus();
  busstate_t dbg_state;

  memory_control dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks;
  int n_pass;
  int n;

  // ---------------- RAM model ----------------
  word_t ram [256];
  int lat;
  bit err_inj;
  logic [3:0] cnt;
  logic strobe;
  logic [7:0] idx;

  assign strobe = bus.ramREN | bus.ramWEN;
  assign idx    = bus.ramaddr[9:2];
  assign bus.ramstate = !strobe ? FREE :
                        (int'(cnt) == lat) ? ACCESS :
                        (err_inj && cnt == 4'd1) ? ERROR : BUSY;
  assign bus.ramload  = strobe ? ram[idx] : '0;

  always @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      for (int i = 0; i < 256; i++) ram[i] <= 32'hC0DE_0000 | word_t'(i * 4);
    end else begin
      cnt <= (!strobe || bus.ramstate == ACCESS) ? 4'd0 : cnt + 4'd1;
      if (bus.ramWEN && bus.ramstate == ACCESS) ram[idx] <= bus.ramstore;
    end
  end

  // ---------------- checking ----------------
  logic [34:0] exp_q[$];

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic expect_ack(input logic core, input logic is_d, input logic has_data, input word_t data);
    exp_q.push_back({core, is_d, has_data, data});
  endtask

  task automatic sb_pop(input logic core, input logic is_d, input word_t data);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_ack: core%0d is_d=%0d data=0x%08h, expected no ack", core, is_d, data);
      return;
    end
    e = exp_q.pop_front();
    chk("ack_source", {30'b0, core, is_d}, {30'b0, e[34], e[33]});
    if (e[32]) chk("ack_data", data, e[31:0]);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      for (int c = 0; c < CPUS; c++) begin
        if (!bus.iwait[c]) sb_pop(1'(c), 1'b0, bus.iload[c]);
        if (!bus.dwait[c]) sb_pop(1'(c), 1'b1, bus.dload[c]);
      end
      chk("invariants", {29'b0, bus.ramREN & bus.ramWEN,
                         ~bus.iwait[1] & ~bus.dwait[1],
                         ~bus.iwait[0] & ~bus.dwait[0]}, 32'h0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // what: 0 = iwait low, 1 = dwait low, 2 = ccwait high
  task automatic wait_for(input int what, input int c, input string name, output int cycles);
    bit hit;
    cycles = 0;
    hit    = 1'b0;
    while (!hit && cycles < 60) begin
      @(negedge CLK);
      cycles++;
      case (what)
        0:       hit = !bus.iwait[c];
        1:       hit = !bus.dwait[c];
        default: hit = bus.ccwait[c];
      endcase
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL timeout_%s: no event after %0d cycles, required within 60", name, cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    lat      = 2;
    err_inj  = 1'b0;
    RST      = 1'b1;
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.ccwrite = '0; bus.cctrans = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    @(negedge CLK);
    chk("rst_state",    32'(dbg_state), 32'(IDLE));
    chk("rst_iwait",    32'(bus.iwait), 32'h3);
    chk("rst_dwait",    32'(bus.dwait), 32'h3);
    chk("rst_cc",       {28'b0, bus.ccwait, bus.ccinv}, 32'h0);
    chk("rst_strobes",  {30'b0, bus.ramREN, bus.ramWEN}, 32'h0);
    chk("rst_ramaddr",  bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    chk("rst_snoop0",   bus.ccsnoopaddr[0], 32'h0);
    chk("rst_snoop1",   bus.ccsnoopaddr[1], 32'h0);

    // 1: core0 fetch, two BUSY cycles before ACCESS
    step();
    expect_ack(1'b0, 1'b0, 1'b1, 32'hC0DE_0040);
    bus.iaddr[0] = 32'h40; bus.iREN[0] = 1'b1;
    wait_for(0, 0, "t1_ifetch", n);
    chk("t1_latency", word_t'(n), 32'd4);
    step(); bus.iREN[0] = 1'b0;

    // 1b: core1 fetch with an ERROR cycle that must count as BUSY
    lat = 3; err_inj = 1'b1;
    step();
    expect_ack(1'b1, 1'b0, 1'b1, 32'hC0DE_0048);
    bus.iaddr[1] = 32'h48; bus.iREN[1] = 1'b1;
    wait_for(0, 1, "t1b_ifetch", n);
    chk("t1b_latency", word_t'(n), 32'd5);
    step(); bus.iREN[1] = 1'b0;
    lat = 2; err_inj = 1'b0;

    // 2: simultaneous fetches, twice, core0 must win each round
    for (int r = 0; r < 2; r++) begin
      step();
      expect_ack(1'b0, 1'b0, 1'b1, 32'hC0DE_0010);
      expect_ack(1'b1, 1'b0, 1'b1, 32'hC0DE_0020);
      bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20; bus.iREN = 2'b11;
      wait_for(0, 0, "t2_core0", n);
      step(); bus.iREN[0] = 1'b0;
      wait_for(0, 1, "t2_core1", n);
      step(); bus.iREN[1] = 1'b0;
    end

    // 3: core0 fill, core1 clean snooper
    step();
    expect_ack(1'b0, 1'b1, 1'b1, 32'hC0DE_0080);
    expect_ack(1'b0, 1'b1, 1'b1, 32'hC0DE_0084);
    bus.daddr[0] = 32'h80; bus.dREN[0] = 1'b1;
    wait_for(2, 1, "t3_snoop", n);
    chk("t3_snoopaddr", bus.ccsnoopaddr[1], 32'h80);
    chk("t3_ccinv", 32'(bus.ccinv[1]), 32'h0);
    step(); bus.cctrans[1] = 1'b1;
    for (int w = 0; w < BLKWORDS; w++) begin
      wait_for(1, 0, "t3_mem", n);
      step(); bus.cctrans[1] = 1'b0;
      if (w == BLKWORDS - 1) bus.dREN[0] = 1'b0;
      else begin
        bus.daddr[0] = 32'h84;
        @(negedge CLK);
        chk("t3_ccwait_mem1", 32'(bus.ccwait[1]), 32'h1);
        chk("t3_ramaddr_mem1", bus.ramaddr, 32'h84);
      end
    end

    // 4: core1 BusRdX, core0 dirty supplies cache-to-cache
    step();
    expect_ack(1'b0, 1'b1, 1'b0, 32'h0);
    expect_ack(1'b1, 1'b1, 1'b1, 32'hAA);
    expect_ack(1'b0, 1'b1, 1'b0, 32'h0);
    expect_ack(1'b1, 1'b1, 1'b1, 32'hBB);
    bus.daddr[1] = 32'h100; bus.ccwrite[1] = 1'b1; bus.dREN[1] = 1'b1;
    wait_for(2, 0, "t4_snoop", n);
    chk("t4_ccinv", 32'(bus.ccinv[0]), 32'h1);
    chk("t4_snoopaddr", bus.ccsnoopaddr[0], 32'h100);
    step();
    bus.cctrans[0] = 1'b1; bus.dWEN[0] = 1'b1;
    bus.daddr[0] = 32'h100; bus.dstore[0] = 32'hAA;
    wait_for(1, 1, "t4_c2c0", n);
    step(); bus.daddr[0] = 32'h104; bus.dstore[0] = 32'hBB; bus.daddr[1] = 32'h104;
    wait_for(1, 1, "t4_c2c1", n);
    step();
    bus.cctrans[0] = 1'b0; bus.dWEN[0] = 1'b0; bus.dREN[1] = 1'b0; bus.ccwrite[1] = 1'b0;
    @(negedge CLK);
    chk("t4_ram_100", ram[64], 32'hAA);
    chk("t4_ram_104", ram[65], 32'hBB);

    // 5: core0 upgrade beats core1 fetch
    step();
    expect_ack(1'b0, 1'b1, 1'b0, 32'h0);
    expect_ack(1'b1, 1'b0, 1'b1, 32'hC0DE_0044);
    bus.daddr[0] = 32'h200; bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1;
    bus.iaddr[1] = 32'h44; bus.iREN[1] = 1'b1;
    wait_for(2, 1, "t5_inv", n);
    chk("t5_ccinv", 32'(bus.ccinv[1]), 32'h1);
    chk("t5_snoopaddr", bus.ccsnoopaddr[1], 32'h200);
    chk("t5_no_ram", {30'b0, bus.ramREN, bus.ramWEN}, 32'h0);
    wait_for(1, 0, "t5_upgrade", n);
    chk("t5_ack_delay", word_t'(n), 32'd1);
    step(); bus.cctrans[0] = 1'b0; bus.ccwrite[0] = 1'b0;
    wait_for(0, 1, "t5_ifetch", n);
    step(); bus.iREN[1] = 1'b0;

    // withdrawn fetch: no ack, back to IDLE
    lat = 6;
    step(); bus.iaddr[1] = 32'h4C; bus.iREN[1] = 1'b1;
    repeat (3) @(negedge CLK);
    step(); bus.iREN[1] = 1'b0;
    repeat (2) @(negedge CLK);
    chk("withdraw_idle", 32'(dbg_state), 32'(IDLE));
    repeat (8) @(negedge CLK);
    lat = 2;

    // 6: reset during MEM1 aborts the fill
    step();
    expect_ack(1'b0, 1'b1, 1'b1, 32'hC0DE_0080);
    bus.daddr[0] = 32'h80; bus.dREN[0] = 1'b1;
    wait_for(2, 1, "t6_snoop", n);
    step(); bus.cctrans[1] = 1'b1;
    wait_for(1, 0, "t6_mem0", n);
    step(); bus.cctrans[1] = 1'b0; bus.daddr[0] = 32'h84;
    @(negedge CLK);
    chk("t6_in_mem1", 32'(dbg_state), 32'(MEM1));
    chk("t6_ramren_mem1", 32'(bus.ramREN), 32'h1);
    step(); RST = 1'b1; bus.dREN[0] = 1'b0;
    step(); RST = 1'b0;
    @(negedge CLK);
    chk("t6_state", 32'(dbg_state), 32'(IDLE));
    chk("t6_ramren", 32'(bus.ramREN), 32'h0);
    chk("t6_iwait", 32'(bus.iwait), 32'h3);
    chk("t6_dwait", 32'(bus.dwait), 32'h3);
    chk("t6_ccwait", 32'(bus.ccwait), 32'h0);

    repeat (4) @(negedge CLK);
    chk("sb_empty", word_t'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
